// File: rtl/filtro_pkg.sv
// Shared definitions for the filter datapath: default operand formats and
// the state encoding of the multiply-accumulate controller.
package filtro_pkg;

  localparam int N_DEF     = 25;
  localparam int FA_DEF    = 14;
  localparam int FB_DEF    = 19;
  localparam int MA_DEF    = N_DEF - 1 - FA_DEF;
  localparam int MB_DEF    = N_DEF - 1 - FB_DEF;
  localparam int TAPS_DEF  = 5;
  localparam int SUM_W_DEF = 2 * N_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_OUT   = 2'd3
  } mac_state_e;

endpackage

// File: rtl/multiplicador_reg.sv
// Registered signed N x N -> 2N multiplier with a valid flag travelling
// alongside the product; the product register holds when no operand is valid.
module multiplicador_reg #(
  parameter int N = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic signed [N-1:0]   a_in,
  input  logic signed [N-1:0]   b_in,
  input  logic                  valid_in,
  output logic signed [2*N-1:0] prod_out,
  output logic                  valid_out
);

  logic signed [2*N-1:0] prod_d, prod_q;
  logic                  valid_d, valid_q;

  always_comb begin
    prod_d  = prod_q;
    valid_d = valid_in;
    if (valid_in) begin
      // Sign-extend both operands to the full product width first.
      prod_d = (2*N)'(a_in) * (2*N)'(b_in);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      prod_q  <= prod_d;
      valid_q <= valid_d;
    end
  end

  assign prod_out  = prod_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/mac_acumulador.sv
// Sequential multiply-accumulate: TAPS operand pairs in, one full-precision
// 2N-bit wrapping sum out, feeding the truncation/saturation stage.
module mac_acumulador
  import filtro_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int TAPS = TAPS_DEF,
  parameter int FA   = FA_DEF,
  parameter int FB   = FB_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [N-1:0] dato_in,
  input  logic signed [N-1:0] coef_in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [2*N-1:0]      sum_out,
  output logic                sum_valid,
  input  logic                sum_ready,
  output logic                busy
);

  localparam int SUM_W = 2 * N;
  localparam int CW    = $clog2(TAPS + 1);
  localparam logic [CW-1:0] LAST_TAP = CW'(TAPS - 1);

  // The sum carries FA+FB fractional bits; it must fit in the product width.
  generate
    if (TAPS < 1 || (FA + FB) > (SUM_W - 2)) begin : g_bad_params
      $error("mac_acumulador: invalid TAPS/FA/FB for N");
    end
  endgenerate

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both high; valid never depends on ready, and data holds while
  // valid is high without ready.
  mac_state_e            state_d, state_q;
  logic [SUM_W-1:0]      acc_d, acc_q;
  logic [CW-1:0]         cnt_d, cnt_q;
  logic [SUM_W-1:0]      sum_d, sum_q;
  logic                  sum_valid_d, sum_valid_q;
  logic                  accept;
  logic signed [SUM_W-1:0] prod;
  logic                  prod_valid;

  assign accept = (state_q == ST_ACC) && in_valid;

  multiplicador_reg #(.N(N)) u_mult (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_in      (dato_in),
    .b_in      (coef_in),
    .valid_in  (accept),
    .prod_out  (prod),
    .valid_out (prod_valid)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    // Only a freshly registered product is added; gaps never re-add.
    if (prod_valid) begin
      acc_d = acc_q + prod;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_TAP) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (!prod_valid) begin
          sum_d   = acc_q;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (sum_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    sum_valid_d = (state_d == ST_OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign busy      = (state_q != ST_IDLE);
  assign sum_out   = sum_q;
  assign sum_valid = sum_valid_q;

endmodule

// File: tb/tb_mac_acumulador.sv
// Bench for mac_acumulador: table vectors, hand-written corner sequences and
// randomized jobs checked against an arithmetic sum-of-products model.
`timescale 1ns/1ps
module tb_mac_acumulador;

  localparam int N    = 25;
  localparam int TAPS = 5;
  localparam int SW   = 2 * N;
  localparam int NP   = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [N-1:0]  dato_in;
  logic [N-1:0]  coef_in;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] sum_out;
  logic          sum_valid;
  logic          sum_ready;
  logic          busy;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mac_acumulador #(.N(N), .TAPS(TAPS), .FA(14), .FB(19)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dato_in   (dato_in),
    .coef_in   (coef_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_out   (sum_out),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .busy      (busy)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [SW-1:0] exp_q[$];
  logic [N-1:0]  pd[NP];
  logic [N-1:0]  pc[NP];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain signed sum of the first TAPS products, modulo 2^(2N).
  function automatic logic [SW-1:0] model_sum();
    longint acc;
    acc = 0;
    for (int i = 0; i < TAPS; i++) begin
      longint a, b;
      a = $signed(pd[i]);
      b = $signed(pc[i]);
      acc += a * b;
    end
    return acc[SW-1:0];
  endfunction

  task automatic fill_const(input logic [N-1:0] d, input logic [N-1:0] c);
    for (int i = 0; i < NP; i++) begin
      pd[i] = (i < TAPS) ? d : N'($urandom_range(1, 1000));
      pc[i] = (i < TAPS) ? c : N'($urandom_range(1, 1000));
    end
  endtask

  // ---------------- driver ----------------
  // Called at #1 after a rising edge with the DUT idle; expected sum is on exp_q.
  task automatic run_job(input string tag, input bit gaps, input int ready_hold,
                         input bit start_noise, input bit start_at_hs);
    int consumed, t0, idx;
    bit done;
    logic [SW-1:0] got, exp;
    consumed  = 0;
    done      = 1'b0;
    sum_ready = (ready_hold == 0);
    start     = 1'b1;
    t0        = int'(cyc);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    for (int k = 0; k < 100 && !done; k++) begin
      idx      = (consumed < NP) ? consumed : NP - 1;
      in_valid = gaps ? (k % 2 == 0) : 1'b1;
      dato_in  = pd[idx];
      coef_in  = pc[idx];
      start    = start_noise && (k == 3);
      if (in_valid && in_ready) consumed++;
      @(posedge clk); #1;
      done = sum_valid;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    exp      = exp_q.pop_front();
    if (!done) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
      sum_ready = 1'b0;
      return;
    end
    if (!gaps) check({tag, "_latency"}, 64'(int'(cyc) - t0), 64'd8);
    check({tag, "_consumed"}, 64'(consumed), 64'(TAPS));
    got = sum_out;
    check({tag, "_sum"}, 64'(got), 64'(exp));
    for (int h = 0; h < ready_hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 64'(sum_valid), 64'd1);
      check({tag, "_hold_sum"}, 64'(sum_out), 64'(got));
    end
    sum_ready = 1'b1;
    start     = start_at_hs;
    @(posedge clk); #1;
    sum_ready = 1'b0;
    start     = 1'b0;
    check({tag, "_valid_drop"}, 64'(sum_valid), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_sum_kept"}, 64'(sum_out), 64'(got));
    if (start_at_hs) begin
      @(posedge clk); #1;
      check({tag, "_start_not_captured"}, 64'(busy), 64'd0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string         name;
    logic [N-1:0]  dato;
    logic [N-1:0]  coef;
    int            ready_hold;
    logic [SW-1:0] exp_sum;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{"unity",    25'd16384,     25'd524288,    0, 50'h000A00000000};
    vecs[1] = '{"negative", 25'h1FFC000,   25'd524288,    3, 50'h3FFF600000000};
    vecs[2] = '{"wrap",     25'h1000000,   25'h1000000,   1, 50'h1000000000000};
    vecs[3] = '{"one_neg1", 25'd1,         25'h1FFFFFF,   2, 50'h3FFFFFFFFFFFB};
    vecs[4] = '{"max_pos",  25'h0FFFFFF,   25'h0FFFFFF,   0, 50'h0FFFFF6000005};

    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    sum_ready = 1'b0;
    dato_in   = '0;
    coef_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_sum_out", 64'(sum_out), 64'd0);
    check("reset_sum_valid", 64'(sum_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      fill_const(vecs[v].dato, vecs[v].coef);
      exp_q.push_back(vecs[v].exp_sum);
      run_job(vecs[v].name, 1'b0, vecs[v].ready_hold, 1'b0, 1'b0);
    end

    // Gaps on in_valid, stray start pulses during ACC, only pair 0 nonzero.
    fill_const('0, '0);
    pd[0] = 25'd16384;
    pc[0] = 25'd524288;
    exp_q.push_back(50'h000200000000);
    run_job("gaps", 1'b1, 1, 1'b1, 1'b0);

    // start coinciding with the output handshake is not captured.
    fill_const(25'd3, 25'd7);
    exp_q.push_back(50'd105);
    run_job("start_at_hs", 1'b0, 0, 1'b0, 1'b1);

    // Reset in the middle of accumulation, then a clean unity job.
    fill_const(25'd16384, 25'd524288);
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    dato_in  = 25'd16384;
    coef_in  = 25'd524288;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_sum_out", 64'(sum_out), 64'd0);
    check("midreset_sum_valid", 64'(sum_valid), 64'd0);
    check("midreset_in_ready", 64'(in_ready), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midreset_no_valid", 64'(sum_valid), 64'd0);
    exp_q.push_back(50'h000A00000000);
    run_job("after_reset", 1'b0, 0, 1'b0, 1'b0);

    // Back-to-back with sum_ready high: start again right after returning idle.
    fill_const(25'd16384, 25'd524288);
    exp_q.push_back(50'h000A00000000);
    run_job("b2b_first", 1'b0, 0, 1'b0, 1'b0);
    fill_const(25'h1FFC000, 25'd524288);
    exp_q.push_back(50'h3FFF600000000);
    run_job("b2b_second", 1'b0, 0, 1'b0, 1'b0);

    // Randomized jobs against the reference model.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NP; i++) begin
        pd[i] = (r % 3 == 0) ? N'($urandom_range(0, 40000)) : N'($urandom());
        pc[i] = (r % 3 == 0) ? N'($urandom_range(0, 600000)) : N'($urandom());
      end
      exp_q.push_back(model_sum());
      run_job($sformatf("rand%0d", r), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
